// File: rtl/vc_deserializer_if.sv
// vc_deserializer_if: phit input, per-VC flow control, flit output and error pulses of vc_deserializer.
interface vc_deserializer_if #(
   parameter int PHIT_W = 4,
   parameter int FLIT_W = 64,
   parameter int NUM_VC = 4
);
   localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
   logic [PHIT_W-1:0] data_in;
   logic              valid_in;
   logic [VC_W-1:0]   vc_in;
   logic [NUM_VC-1:0] vc_ready;
   logic [FLIT_W-1:0] data_out;
   logic              valid_out;
   logic [VC_W-1:0]   vc_out;
   logic              ready_in;
   logic              drop_err;
   logic              timeout_err;
   modport master (
      output data_in, valid_in, vc_in, ready_in,
      input  vc_ready, data_out, valid_out, vc_out, drop_err, timeout_err
   );
   modport slave (
      input  data_in, valid_in, vc_in, ready_in,
      output vc_ready, data_out, valid_out, vc_out, drop_err, timeout_err
   );
endinterface

// File: rtl/vc_deserializer.sv
// vc_deserializer: per-VC phit-to-flit assembly with a round-robin single-entry flit output.
// Define DESER_TIMEOUT_EN to abort partial flits that stay idle for TIMEOUT cycles.
module vc_deserializer #(
   parameter int PHIT_W  = 4,
   parameter int FLIT_W  = 64,
   parameter int NUM_VC  = 4,
   parameter int TIMEOUT = 32
) (
   input logic clk,
   input logic rst,
   vc_deserializer_if.slave bus
);
   localparam int PHITS = FLIT_W / PHIT_W;
   localparam int VC_W  = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
   localparam int CNT_W = PHITS > 1 ? $clog2(PHITS) : 1;
   logic [FLIT_W-1:0] asm_q [NUM_VC];
   logic [CNT_W-1:0]  cnt_q [NUM_VC];
   logic [NUM_VC-1:0] complete_q;
   logic [NUM_VC-1:0] abort;
   logic [VC_W-1:0]   ptr_q;
   logic [VC_W-1:0]   gnt;
   logic              found;
   logic              accept;
   logic              last;
   int                idx;
   assign bus.vc_ready = ~complete_q;
   assign accept = bus.valid_in && (int'(bus.vc_in) < NUM_VC) && !complete_q[bus.vc_in];
   assign last   = cnt_q[bus.vc_in] == CNT_W'(PHITS - 1);
   // Scan downward so the VC closest to ptr_q is the final, winning assignment.
   always_comb begin
      gnt   = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = NUM_VC - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NUM_VC;
         if (complete_q[idx]) begin
            gnt   = VC_W'(idx);
            found = 1'b1;
         end
      end
   end
`ifdef DESER_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q [NUM_VC];
   always_comb begin
      abort = '0;
      for (int v = 0; v < NUM_VC; v++)
         abort[v] = cnt_q[v] != '0 && !(accept && int'(bus.vc_in) == v) && idle_q[v] == IDLE_W'(TIMEOUT - 1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int v = 0; v < NUM_VC; v++) idle_q[v] <= '0;
      else
         for (int v = 0; v < NUM_VC; v++)
            idle_q[v] <= (abort[v] || cnt_q[v] == '0 || (accept && int'(bus.vc_in) == v)) ? '0 : idle_q[v] + 1'b1;
`else
   assign abort = '0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            asm_q[v] <= '0;
            cnt_q[v] <= '0;
         end
         complete_q      <= '0;
         ptr_q           <= '0;
         bus.data_out    <= '0;
         bus.vc_out      <= '0;
         bus.valid_out   <= 1'b0;
         bus.drop_err    <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.drop_err    <= bus.valid_in && !accept;
         bus.timeout_err <= |abort;
         for (int v = 0; v < NUM_VC; v++)
            if (abort[v]) begin
               cnt_q[v] <= '0;
               asm_q[v] <= '0;
            end else if (accept && int'(bus.vc_in) == v) begin
               asm_q[v][int'(cnt_q[v]) * PHIT_W +: PHIT_W] <= bus.data_in;
               cnt_q[v] <= last ? '0 : cnt_q[v] + 1'b1;
            end
         if (found && (!bus.valid_out || bus.ready_in)) complete_q[gnt] <= 1'b0;
         if (accept && last) complete_q[bus.vc_in] <= 1'b1;
         if (!bus.valid_out || bus.ready_in) begin
            bus.valid_out <= found;
            if (found) begin
               bus.data_out <= asm_q[gnt];
               bus.vc_out   <= gnt;
               ptr_q        <= int'(gnt) == NUM_VC - 1 ? '0 : gnt + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_vc_deserializer.sv
// tb_vc_deserializer: directed vectors with hand-computed flits for vc_deserializer.
module tb_vc_deserializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   vc_deserializer_if #(.PHIT_W(4), .FLIT_W(64), .NUM_VC(4)) bus ();
   vc_deserializer #(.PHIT_W(4), .FLIT_W(64), .NUM_VC(4), .TIMEOUT(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [1:0] vc, input logic [3:0] d);
      bus.valid_in = 1'b1;
      bus.vc_in    = vc;
      bus.data_in  = d;
      step();
      bus.valid_in = 1'b0;
   endtask
   initial begin
      bus.valid_in = 1'b0;
      bus.vc_in    = '0;
      bus.data_in  = '0;
      bus.ready_in = 1'b1;
      step();
      check("rst_valid", bus.valid_out, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_vc", bus.vc_out, 0);
      check("rst_drop", bus.drop_err, 0);
      check("rst_tmo", bus.timeout_err, 0);
      check("rst_ready", bus.vc_ready, 4'hF);
      rst = 1'b0;
      step();
      // single flit on VC2, nibble i+1 in phit i
      for (int i = 0; i < 16; i++) send(2'd2, 4'((i + 1) & 15));
      check("vc2_latency", bus.valid_out, 0);
      step();
      check("vc2_valid", bus.valid_out, 1);
      check("vc2_data", bus.data_out, 64'h0FED_CBA9_8765_4321);
      check("vc2_vc", bus.vc_out, 2);
      step();
      check("vc2_one_cycle", bus.valid_out, 0);
      // interleaved VC0/VC1
      for (int c = 0; c < 32; c++) send(2'(c % 2), (c % 2) != 0 ? 4'h5 : 4'hA);
      check("il_vc0_valid", bus.valid_out, 1);
      check("il_vc0_data", bus.data_out, 64'hAAAA_AAAA_AAAA_AAAA);
      check("il_vc0_vc", bus.vc_out, 0);
      step();
      check("il_vc1_data", bus.data_out, 64'h5555_5555_5555_5555);
      check("il_vc1_vc", bus.vc_out, 1);
      step();
      check("il_idle", bus.valid_out, 0);
      // backpressure with VC0 and VC3 pending
      bus.ready_in = 1'b0;
      for (int i = 0; i < 16; i++) send(2'd0, 4'h3);
      for (int i = 0; i < 16; i++) send(2'd3, 4'hC);
      check("bp_vc_ready", bus.vc_ready, 4'b0111);
      check("bp_hold_vc", bus.vc_out, 0);
      check("bp_hold_data", bus.data_out, 64'h3333_3333_3333_3333);
      send(2'd3, 4'hF);
      check("bp_drop", bus.drop_err, 1);
      step();
      check("bp_drop_pulse", bus.drop_err, 0);
      check("bp_still_valid", bus.valid_out, 1);
      check("bp_still_vc0", bus.data_out, 64'h3333_3333_3333_3333);
      bus.ready_in = 1'b1;
      check("bp_xfer_vc0", bus.vc_out, 0);
      step();
      check("bp_xfer_vc3", bus.vc_out, 3);
      check("bp_vc3_data", bus.data_out, 64'hCCCC_CCCC_CCCC_CCCC);
      check("bp_vc3_valid", bus.valid_out, 1);
      check("bp_vc3_ready_back", bus.vc_ready, 4'hF);
      step();
      check("bp_idle", bus.valid_out, 0);
      // idle partial flit on VC1
      for (int i = 0; i < 5; i++) send(2'd1, 4'h7);
`ifdef DESER_TIMEOUT_EN
      for (int i = 0; i < 31; i++) step();
      check("tmo_early", bus.timeout_err, 0);
      step();
      check("tmo_pulse", bus.timeout_err, 1);
      step();
      check("tmo_pulse_end", bus.timeout_err, 0);
      for (int i = 0; i < 16; i++) send(2'd1, 4'h1);
      step();
      check("tmo_new_data", bus.data_out, 64'h1111_1111_1111_1111);
`else
      for (int i = 0; i < 40; i++) step();
      check("hold_no_tmo", bus.timeout_err, 0);
      check("hold_no_flit", bus.valid_out, 0);
      for (int i = 0; i < 11; i++) send(2'd1, 4'h1);
      step();
      check("hold_data", bus.data_out, 64'h1111_1111_1117_7777);
`endif
      check("part_valid", bus.valid_out, 1);
      check("part_vc", bus.vc_out, 1);
      step();
      // reset mid-operation with a flit held and a partial flit on VC0
      bus.ready_in = 1'b0;
      for (int i = 0; i < 16; i++) send(2'd2, 4'h6);
      step();
      check("mid_held", bus.valid_out, 1);
      for (int i = 0; i < 8; i++) send(2'd0, 4'h9);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.valid_out, 0);
      check("mid_rst_data", bus.data_out, 0);
      check("mid_rst_ready", bus.vc_ready, 4'hF);
      #1;
      rst = 1'b0;
      bus.ready_in = 1'b1;
      step();
      step();
      check("post_rst_no_flit", bus.valid_out, 0);
      for (int i = 0; i < 16; i++) send(2'd0, 4'h2);
      step();
      check("post_rst_valid", bus.valid_out, 1);
      check("post_rst_data", bus.data_out, 64'h2222_2222_2222_2222);
      check("post_rst_vc", bus.vc_out, 0);
      step();
      check("post_rst_single", bus.valid_out, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vc_deserializer.md
VC_DESERIALIZER -- requirements
Module: vc_deserializer

Interface
REQ-001 SHALL have parameter PHIT_W, default 4: input phit width in bits.
REQ-002 SHALL have parameter FLIT_W, default 64: output flit width; FLIT_W multiple of PHIT_W; PHITS = FLIT_W/PHIT_W.
REQ-003 SHALL have parameter NUM_VC, default 4: number of virtual channels; VC_W = max(1, clog2(NUM_VC)).
REQ-004 SHALL have parameter TIMEOUT, default 32: idle-cycle limit for a partial flit (used only under DESER_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1: clock, rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port data_in  input  PHIT_W: phit payload.
REQ-008 SHALL have port valid_in  input  1: phit present this cycle.
REQ-009 SHALL have port vc_in  input  VC_W: VC of the current phit.
REQ-010 SHALL have port vc_ready  output  NUM_VC: per-VC permission to send phits.
REQ-011 SHALL have port data_out  output  FLIT_W: assembled flit.
REQ-012 SHALL have port valid_out  output  1: data_out/vc_out valid.
REQ-013 SHALL have port vc_out  output  VC_W: VC of data_out.
REQ-014 SHALL have port ready_in  input  1: downstream accepts the flit when valid_out and ready_in are both high.
REQ-015 SHALL have port drop_err  output  1: one-cycle pulse when a phit is discarded.
REQ-016 SHALL have port timeout_err  output  1: one-cycle pulse when a partial flit is aborted.

Function
REQ-017 SHALL keep a separate assembly register, phit counter (0..PHITS-1) and complete flag for each VC, so phits of different VCs may interleave on any cycle boundary.
REQ-018 SHALL write phit number i of a VC into bits [i*PHIT_W +: PHIT_W]; phit 0 fills the LSBs.
REQ-019 SHALL capture a phit on an edge where valid_in=1, vc_in<NUM_VC and vc_ready[vc_in]=1, then increment that VC's counter.
REQ-020 SHALL, when phit PHITS-1 is captured, set that VC's complete flag and reset its counter to 0 on the same edge.
REQ-021 SHALL drive vc_ready[v] = !complete[v] combinationally.
REQ-022 SHALL discard a phit with vc_in>=NUM_VC or vc_ready[vc_in]=0, leave all state unchanged, and pulse drop_err on the following cycle.
REQ-023 SHALL load the single output register on an edge where (valid_out=0 or ready_in=1) and at least one complete flag is set; the VC is chosen round-robin starting from the VC after the last one granted; the granted VC's complete flag clears on the same edge.
REQ-024 SHALL hold data_out, vc_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-025 SHALL give a minimum latency of one edge: if the final phit is captured at edge T and the output register is free, valid_out is high after edge T+1.
REQ-026 SHALL sustain one flit per cycle of output throughput when ready_in stays high and complete flags are pending.
REQ-027 SHALL accept a new phit on a VC on the edge that clears its complete flag only if vc_ready for that VC was already high in that cycle; otherwise the phit is dropped per REQ-022.

Reset
REQ-028 SHALL, while rst=1, clear all counters, complete flags, assembly registers, the round-robin pointer (next grant VC 0), data_out=0, vc_out=0, valid_out=0, drop_err=0, timeout_err=0; vc_ready = all ones.
REQ-029 SHALL discard all partial and completed flits when rst asserts mid-operation; no flit is emitted after reset releases until PHITS new phits are received on one VC.

Configuration
REQ-030 SHALL, with DESER_TIMEOUT_EN defined, keep a per-VC idle counter that clears on each captured phit for that VC and increments while the VC counter is nonzero; when it reaches TIMEOUT, the VC counter and idle counter clear, the partial data is discarded, and timeout_err pulses for one cycle.
REQ-031 SHALL, without DESER_TIMEOUT_EN, hold partial flits indefinitely, omit the idle counters, and tie timeout_err to 0.

Verification
REQ-032 SHALL cover: 16 phits 0x1..0xF,0x0 on VC2, ready_in=1 -> one flit with data_out=0x0FEDCBA987654321, vc_out=2, valid_out high one cycle.
REQ-033 SHALL cover: phits alternating VC0 (all 0xA) and VC1 (all 0x5), 32 cycles -> flits 0xAAAA_AAAA_AAAA_AAAA on VC0 and then 0x5555_5555_5555_5555 on VC1, in that order.
REQ-034 SHALL cover: ready_in=0 with VC0 and VC3 flits completing -> output holds the VC0 flit, vc_ready[3]=0; a phit sent on VC3 pulses drop_err; with ready_in=1 the next two cycles give VC0 then VC3.
REQ-035 SHALL cover: DESER_TIMEOUT_EN, TIMEOUT=32, 5 phits on VC1, then 32 idle cycles -> timeout_err pulses; 16 new phits on VC1 give a flit containing only the new data.
REQ-036 SHALL cover: rst asserted after 8 phits on VC0 -> all outputs at reset values immediately; 16 phits after release give exactly one correct flit.
